// File: rtl/gr8ram_pkg.sv
// rtl/gr8ram_pkg.sv - shared SPI opcodes, loader states and image layout for the gr8ram init path
package gr8ram_pkg;

    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam logic [7:0] SPI_OP_FREAD = 8'h0B;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        FINISH
    } loaderState_t;

    // Flash layout shared with the SDRAM init sequencer; lengths are bytes minus one
    localparam logic [23:0] DRIVER_IMG_ADDR = 24'h000000;
    localparam logic [24:0] DRIVER_IMG_LEN  = 25'h0000FFF;
    localparam logic [23:0] DISK_IMG_ADDR   = 24'h001000;
    localparam logic [24:0] DISK_IMG_LEN    = 25'h003FFFF;

endpackage

// File: rtl/spi_nor_shift.sv
// rtl/spi_nor_shift.sv - SPI mode-0 bit engine: FCK phase, bidirectional shift register, byte strobe
module spi_nor_shift (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clkHold,
    input  logic       load,
    input  logic [7:0] loadData,
    input  logic       take,
    input  logic       miso,
    output logic       fck,
    output logic       mosi,
    output logic [7:0] rxByte,
    output logic       full
);

    logic [7:0] shiftReg;
    logic [2:0] bitCnt;

    assign rxByte = shiftReg;

    // MISO enters on the rising edge; MOSI is re-registered on the falling edge so it
    // stays stable across the whole high phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            fck      <= 1'b0;
            mosi     <= 1'b0;
            shiftReg <= 8'h00;
            bitCnt   <= 3'd0;
            full     <= 1'b0;
        end else if (load) begin
            fck      <= 1'b0;
            mosi     <= loadData[7];
            shiftReg <= loadData;
            bitCnt   <= 3'd0;
            full     <= 1'b0;
        end else if (!run) begin
            fck    <= 1'b0;
            mosi   <= 1'b0;
            bitCnt <= 3'd0;
            full   <= 1'b0;
        end else begin
            if (take) begin
                full <= 1'b0;
            end
            if (fck) begin
                fck  <= 1'b0;
                mosi <= shiftReg[7];
            end else if (!full && !clkHold) begin
                // A completed byte blocks further rises until it has been taken
                fck      <= 1'b1;
                shiftReg <= {shiftReg[6:0], miso};
                if (bitCnt == 3'd7) begin
                    bitCnt <= 3'd0;
                    full   <= 1'b1;
                end else begin
                    bitCnt <= bitCnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_nor_loader.sv
// rtl/spi_nor_loader.sv - SPI NOR image reader feeding the SDRAM init writer as a byte stream
// Define SPI_NOR_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks.
module spi_nor_loader
    import gr8ram_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 25
) (
    input  logic              C25M,
    input  logic              RES,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [LEN_W-1:0]  Len,
    output logic              Busy,
    output logic              Done,
    output logic [7:0]        DOut,
    output logic              DValid,
    input  logic              DReady,
    output logic              nFCS,
    output logic              FCK,
    output logic              MOSI,
    input  logic              MISO
);

`ifdef SPI_NOR_FAST_READ_EN
    localparam logic [7:0] OPCODE = SPI_OP_FREAD;
    localparam loaderState_t AFTER_ADDR = DUMMY;
`else
    localparam logic [7:0] OPCODE = SPI_OP_READ;
    localparam loaderState_t AFTER_ADDR = DATA;
`endif
    localparam logic [1:0] LAST_ADDR_IDX = 2'(ADDR_W / 8 - 1);

    loaderState_t      state, nextState;
    logic [ADDR_W-1:0] addrReg;
    logic [1:0]        addrIdx;
    logic [LEN_W-1:0]  byteCnt;
    logic [7:0]        holdReg;
    logic              holdValid;

    logic       run, clkHold, load, take, full, accept;
    logic [7:0] loadData, rxByte;

    spi_nor_shift u_shift (
        .clk      (C25M),
        .rst      (RES),
        .run      (run),
        .clkHold  (clkHold),
        .load     (load),
        .loadData (loadData),
        .take     (take),
        .miso     (MISO),
        .fck      (FCK),
        .mosi     (MOSI),
        .rxByte   (rxByte),
        .full     (full)
    );

    assign accept = holdValid && DReady;
    assign DValid = holdValid;
    assign DOut   = holdReg;

    always_ff @(posedge C25M) begin
        if (RES) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        load      = 1'b0;
        loadData  = 8'h00;
        take      = 1'b0;
        Done      = 1'b0;
        run       = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
        // Stop clocking once the holding register carries the final byte of the image
        clkHold   = (state == DATA) && holdValid && (byteCnt == '0);
        case (state)
            IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    loadData  = OPCODE;
                    nextState = CMD;
                end
            end
            CMD: begin
                if (full) begin
                    load      = 1'b1;
                    loadData  = addrReg[ADDR_W-1 -: 8];
                    nextState = ADDR;
                end
            end
            ADDR: begin
                if (full) begin
                    load = 1'b1;
                    if (addrIdx == LAST_ADDR_IDX) begin
                        nextState = AFTER_ADDR;
                    end else begin
                        loadData = addrReg[ADDR_W-1 -: 8];
                    end
                end
            end
            DUMMY: begin
                if (full) begin
                    load      = 1'b1;
                    nextState = DATA;
                end
            end
            DATA: begin
                if (full && (!holdValid || accept)) begin
                    take = 1'b1;
                end
                if (accept && (byteCnt == '0)) begin
                    nextState = FINISH;
                end
            end
            FINISH: begin
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        Busy = run;
        nFCS = !run;
    end

    always_ff @(posedge C25M) begin
        if (RES) begin
            addrReg   <= '0;
            addrIdx   <= 2'd0;
            byteCnt   <= '0;
            holdReg   <= 8'h00;
            holdValid <= 1'b0;
        end else begin
            if ((state == IDLE) && Start) begin
                addrReg <= StartAddr;
                addrIdx <= 2'd0;
                byteCnt <= Len;
            end
            if (load && ((state == CMD) || (state == ADDR))) begin
                addrReg <= addrReg << 8;
            end
            if (load && (state == ADDR)) begin
                addrIdx <= addrIdx + 2'd1;
            end
            if (take) begin
                holdReg   <= rxByte;
                holdValid <= 1'b1;
            end else if (accept) begin
                holdValid <= 1'b0;
            end
            if (accept) begin
                byteCnt <= byteCnt - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_nor_loader.sv
// tb/tb_spi_nor_loader.sv - directed bench with SPI NOR flash model and stream scoreboard
module tb_spi_nor_loader;

`ifdef SPI_NOR_FAST_READ_EN
    localparam int HDR_BITS = 40;
    localparam logic [7:0] EXP_OP = 8'h0B;
`else
    localparam int HDR_BITS = 32;
    localparam logic [7:0] EXP_OP = 8'h03;
`endif
    localparam int DLY = (HDR_BITS - 32) * 2;

    logic        C25M, RES, Start, DReady, MISO;
    logic [23:0] StartAddr;
    logic [24:0] Len;
    logic        Busy, Done, DValid, nFCS, FCK, MOSI;
    logic [7:0]  DOut;

    spi_nor_loader dut (
        .C25M(C25M), .RES(RES), .Start(Start), .StartAddr(StartAddr), .Len(Len),
        .Busy(Busy), .Done(Done), .DOut(DOut), .DValid(DValid), .DReady(DReady),
        .nFCS(nFCS), .FCK(FCK), .MOSI(MOSI), .MISO(MISO)
    );

    initial C25M = 1'b0;
    always #5 C25M = ~C25M;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Flash: header bits captured on FCK rise, data driven MSB first after each FCK fall
    logic [7:0]  flashData [64];
    logic [39:0] hdr;
    int          bitIdx;
    int          riseCnt;

    initial MISO = 1'b0;

    always @(negedge nFCS) begin
        bitIdx  = 0;
        riseCnt = 0;
        hdr     = '0;
    end

    always @(posedge FCK) begin
        if (!nFCS) begin
            riseCnt++;
            if (bitIdx < HDR_BITS) hdr = {hdr[38:0], MOSI};
            bitIdx++;
        end
    end

    always @(negedge FCK) begin
        int off;
        int bpos;
        logic [7:0] b;
        if (!nFCS && bitIdx >= HDR_BITS) begin
            off  = (bitIdx - HDR_BITS) / 8;
            bpos = (bitIdx - HDR_BITS) % 8;
            if (off < 64) begin
                b    = flashData[off];
                MISO = b[7 - bpos];
            end
        end
    end

    // Transaction-level model: busy window, remaining count, expected byte queue
    logic       armed = 1'b0;
    logic       mBusy = 1'b0;
    logic       mDone = 1'b0;
    int         mRem = 0;
    logic [7:0] expQ[$];
    logic       prevStall = 1'b0;
    logic [7:0] prevD = 8'h00;
    logic       ncsWasLow = 1'b0;
    int         relCyc = 0;
    int         firstValidRel = -1;
    logic [7:0] firstData = 8'h00;
    int         doneRel = -1;
    int         nfcsHighRel = -1;
    int         hsRel [8];
    int         hsCnt = 0;

    always @(negedge C25M) begin
        logic [7:0] e;
        relCyc++;
        if (RES) armed = 1'b1;
        if (armed) begin
            check("busy", 32'(Busy), 32'(mBusy));
            check("nfcs", 32'(nFCS), 32'(!mBusy));
            check("done", 32'(Done), 32'(mDone));
            if (!mBusy) begin
                check("fck_idle", 32'(FCK), 0);
                check("dvalid_idle", 32'(DValid), 0);
            end
            if (prevStall) begin
                check("dvalid_hold", 32'(DValid), 1);
                check("dout_hold", 32'(DOut), 32'(prevD));
            end
            if (mBusy && DValid && DReady) begin
                if (expQ.size() == 0) begin
                    check("extra_byte", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    check("data", 32'(DOut), 32'(e));
                end
                if (hsCnt < 8) hsRel[hsCnt] = relCyc;
                hsCnt++;
            end
            if (DValid && firstValidRel < 0) begin
                firstValidRel = relCyc;
                firstData = DOut;
            end
            if (Done) doneRel = relCyc;
            if (nFCS && ncsWasLow) begin
                nfcsHighRel = relCyc;
                ncsWasLow = 1'b0;
            end
            if (!nFCS) ncsWasLow = 1'b1;
            prevStall = DValid && !DReady && !RES;
            prevD = DOut;

            mDone = 1'b0;
            if (RES) begin
                mBusy = 1'b0;
                expQ.delete();
            end else if (mBusy) begin
                if (DValid && DReady) begin
                    mRem--;
                    if (mRem == 0) begin
                        mBusy = 1'b0;
                        mDone = 1'b1;
                    end
                end
            end else if (Start) begin
                mBusy = 1'b1;
                mRem = int'(Len) + 1;
                expQ.delete();
                for (int i = 0; i <= int'(Len) && i < 64; i++) expQ.push_back(flashData[i]);
                relCyc = 0;
                firstValidRel = -1;
                doneRel = -1;
                nfcsHighRel = -1;
                hsCnt = 0;
            end
        end
    end

    task automatic startXfer(input logic [23:0] a, input logic [24:0] l);
        @(posedge C25M); #1;
        StartAddr = a;
        Len = l;
        Start = 1'b1;
        @(posedge C25M); #1;
        Start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge C25M);
            if (doneRel >= 0) break;
        end
        check(name, 32'(doneRel >= 0), 1);
        repeat (4) @(posedge C25M);
        #1;
    endtask

    task automatic checkHdr(input string name, input logic [23:0] a);
        check({name, "_op"}, 32'(hdr[HDR_BITS-1 -: 8]), 32'(EXP_OP));
        check({name, "_addr"}, 32'(hdr[HDR_BITS-9 -: 24]), 32'(a));
`ifdef SPI_NOR_FAST_READ_EN
        check({name, "_dummy"}, 32'(hdr[7:0]), 0);
`endif
    endtask

    initial begin
        RES = 1'b1;
        Start = 1'b0;
        StartAddr = '0;
        Len = '0;
        DReady = 1'b1;
        for (int i = 0; i < 64; i++) flashData[i] = 8'h00;
        repeat (3) @(posedge C25M);
        @(negedge C25M);
        check("rst_nfcs", 32'(nFCS), 1);
        check("rst_fck", 32'(FCK), 0);
        check("rst_mosi", 32'(MOSI), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_dvalid", 32'(DValid), 0);
        check("rst_dout", 32'(DOut), 0);
        @(posedge C25M); #1;
        RES = 1'b0;

        // Single byte
        flashData[0] = 8'hA5;
        startXfer(24'h012345, 25'd0);
        waitDone("t1_done_seen");
        checkHdr("t1", 24'h012345);
        check("t1_first_valid", 32'(firstValidRel), 32'(81 + DLY));
        check("t1_first_data", 32'(firstData), 32'hA5);
        check("t1_done_cyc", 32'(doneRel), 32'(82 + DLY));
        check("t1_nfcs_cyc", 32'(nfcsHighRel), 32'(82 + DLY));
        check("t1_rises", 32'(riseCnt), 32'(HDR_BITS + 8));
        check("t1_hs", 32'(hsCnt), 1);

        // Four bytes, no back-pressure
        flashData[0] = 8'h11; flashData[1] = 8'h22; flashData[2] = 8'h33; flashData[3] = 8'h44;
        startXfer(24'h000100, 25'd3);
        waitDone("t2_done_seen");
        checkHdr("t2", 24'h000100);
        check("t2_hs_cnt", 32'(hsCnt), 4);
        check("t2_hs0", 32'(hsRel[0]), 32'(81 + DLY));
        check("t2_hs1", 32'(hsRel[1]), 32'(97 + DLY));
        check("t2_hs2", 32'(hsRel[2]), 32'(113 + DLY));
        check("t2_hs3", 32'(hsRel[3]), 32'(129 + DLY));
        repeat (40) @(posedge C25M);
        check("t2_rises", 32'(riseCnt), 32'(HDR_BITS + 32));

        // Back-pressure: consumer holds off for 50 cycles after the first DValid
        flashData[0] = 8'hC3; flashData[1] = 8'h5A; flashData[2] = 8'h0F;
        DReady = 1'b0;
        startXfer(24'h7E0000, 25'd2);
        repeat (119 + DLY) @(posedge C25M);
        @(negedge C25M);
        check("t3_frozen_fck", 32'(FCK), 0);
        check("t3_frozen_rises", 32'(riseCnt), 32'(HDR_BITS + 16));
        check("t3_first_valid", 32'(firstValidRel), 32'(81 + DLY));
        repeat (11) @(posedge C25M);
        #1;
        DReady = 1'b1;
        waitDone("t3_done_seen");
        check("t3_hs0", 32'(hsRel[0]), 32'(131 + DLY));
        check("t3_hs1", 32'(hsRel[1]), 32'(132 + DLY));
        check("t3_hs2", 32'(hsRel[2]), 32'(148 + DLY));
        check("t3_done_cyc", 32'(doneRel), 32'(149 + DLY));
        check("t3_rises", 32'(riseCnt), 32'(HDR_BITS + 24));

        // Reset mid-transfer, then a clean restart
        flashData[0] = 8'h5A; flashData[1] = 8'h96;
        startXfer(24'h333333, 25'd7);
        repeat (39) @(posedge C25M);
        #1;
        RES = 1'b1;
        @(posedge C25M); #1;
        RES = 1'b0;
        @(negedge C25M);
        check("t4_nfcs", 32'(nFCS), 1);
        check("t4_fck", 32'(FCK), 0);
        check("t4_busy", 32'(Busy), 0);
        check("t4_dvalid", 32'(DValid), 0);
        startXfer(24'hABCDEF, 25'd1);
        waitDone("t4_done_seen");
        checkHdr("t4", 24'hABCDEF);
        check("t4_hs", 32'(hsCnt), 2);
        check("t4_rises", 32'(riseCnt), 32'(HDR_BITS + 16));

        // Start while busy is ignored
        flashData[0] = 8'h77; flashData[1] = 8'h88;
        startXfer(24'h00F0F0, 25'd1);
        repeat (18) @(posedge C25M);
        #1;
        StartAddr = 24'hFFFFFF;
        Len = 25'd5;
        Start = 1'b1;
        @(posedge C25M); #1;
        Start = 1'b0;
        waitDone("t5_done_seen");
        checkHdr("t5", 24'h00F0F0);
        check("t5_hs", 32'(hsCnt), 2);
        check("t5_done_cyc", 32'(doneRel), 32'(98 + DLY));
        check("t5_rises", 32'(riseCnt), 32'(HDR_BITS + 16));

        repeat (5) @(posedge C25M);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
